// File: rtl/ddr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr_arbiter_if
// Purpose  : Bundles the requester-side and DDR-controller-side signals of
//            the three-way DDR burst arbiter.
// Ports    : slave  - arbiter view (takes requests and controller strobes,
//                     drives grant/done/routed strobes and the burst command)
//            master - environment view (requesters plus DDR controller)
// Revision : 1.0 - initial release
// ============================================================================
interface ddr_arbiter_if #(
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int BURST_LEN_WIDTH = 10,
  parameter int NUM_REQ         = 3
);
  // requester side
  logic [NUM_REQ-1:0]                 req_rd;
  logic [NUM_REQ-1:0]                 req_wr;
  logic [NUM_REQ*DDR_ADDR_WIDTH-1:0]  req_addr;
  logic [NUM_REQ*BURST_LEN_WIDTH-1:0] req_len;
  logic [NUM_REQ-1:0]                 grant;
  logic [NUM_REQ-1:0]                 done;
  logic [NUM_REQ-1:0]                 rd_valid;
  logic [NUM_REQ-1:0]                 wr_data_req;
  // DDR controller side
  logic                               rd_burst_req;
  logic                               wr_burst_req;
  logic [DDR_ADDR_WIDTH-1:0]          burst_addr;
  logic [BURST_LEN_WIDTH-1:0]         burst_len;
  logic [BURST_LEN_WIDTH-1:0]         beat_cnt;
  logic                               rd_burst_data_valid;
  logic                               wr_burst_data_req;
  logic                               rd_burst_finish;
  logic                               wr_burst_finish;

  modport slave (
    input  req_rd, req_wr, req_addr, req_len,
    input  rd_burst_data_valid, wr_burst_data_req, rd_burst_finish, wr_burst_finish,
    output grant, done, rd_valid, wr_data_req,
    output rd_burst_req, wr_burst_req, burst_addr, burst_len, beat_cnt
  );

  modport master (
    output req_rd, req_wr, req_addr, req_len,
    output rd_burst_data_valid, wr_burst_data_req, rd_burst_finish, wr_burst_finish,
    input  grant, done, rd_valid, wr_data_req,
    input  rd_burst_req, wr_burst_req, burst_addr, burst_len, beat_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ddr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr_arbiter
// Purpose  : Round-robin arbiter granting one of three requesters (icache,
//            dcache, context save/restore) a single read or write burst on
//            the DDR controller at a time.
// Ports    : clk - rising-edge clock
//            rst - asynchronous active-low reset
//            bus - ddr_arbiter_if.slave: requests in, grant/done/routed
//                  strobes out, registered burst command to the controller
// Revision : 1.0 - initial release
// ============================================================================
module ddr_arbiter #(
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int BURST_LEN_WIDTH = 10,
  parameter int NUM_REQ         = 3
) (
  input  logic         clk,
  input  logic         rst,
  ddr_arbiter_if.slave bus
);

  localparam logic [BURST_LEN_WIDTH-1:0] c_len_one = {{(BURST_LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NUM_REQ-1:0]         c_oh_one  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARB      = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                     r_state, w_next;
  logic [NUM_REQ-1:0]         r_grant, r_done;
  logic [1:0]                 r_last_grant;
  logic                       r_rd_burst_req, r_wr_burst_req;
  logic [DDR_ADDR_WIDTH-1:0]  r_burst_addr;
  logic [BURST_LEN_WIDTH-1:0] r_burst_len, r_beat_cnt;

  logic [NUM_REQ-1:0]         w_pend;
  logic                       w_found;
  logic [1:0]                 w_sel;
  logic                       w_sel_wr;
  logic [NUM_REQ-1:0]         w_sel_oh;
  logic [BURST_LEN_WIDTH-1:0] w_sel_len;
  logic [DDR_ADDR_WIDTH-1:0]  w_addr [NUM_REQ];
  logic [BURST_LEN_WIDTH-1:0] w_len  [NUM_REQ];
  logic                       w_rd_strobe, w_wr_strobe;

  // Unpack the flat per-requester address/length buses into arrays.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_addr[gi] = bus.req_addr[gi*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
    assign w_len[gi]  = bus.req_len[gi*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
  end

  assign w_pend  = bus.req_rd | bus.req_wr;
  assign w_found = |w_pend;

  // Round-robin search starting one past the last winner.
  always_comb begin
    w_sel = 2'd0;
    case (r_last_grant)
      2'd0: begin
        if (w_pend[1])      w_sel = 2'd1;
        else if (w_pend[2]) w_sel = 2'd2;
        else                w_sel = 2'd0;
      end
      2'd1: begin
        if (w_pend[2])      w_sel = 2'd2;
        else if (w_pend[0]) w_sel = 2'd0;
        else                w_sel = 2'd1;
      end
      default: begin
        if (w_pend[0])      w_sel = 2'd0;
        else if (w_pend[1]) w_sel = 2'd1;
        else                w_sel = 2'd2;
      end
    endcase
  end

  // Writes take priority when the winner asks for both directions.
  assign w_sel_wr  = bus.req_wr[w_sel];
  assign w_sel_oh  = c_oh_one << w_sel;
  assign w_sel_len = (w_len[w_sel] == '0) ? c_len_one : w_len[w_sel];

  // Controller strobes only count while a burst of that direction is active.
  assign w_rd_strobe = bus.rd_burst_data_valid && (r_state == RD_BURST);
  assign w_wr_strobe = bus.wr_burst_data_req   && (r_state == WR_BURST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_found) w_next = ARB;
      ARB: begin
        // Requests withdrawn before arbitration simply return to IDLE.
        if (!w_found)     w_next = IDLE;
        else if (w_sel_wr) w_next = WR_BURST;
        else               w_next = RD_BURST;
      end
      RD_BURST: if (bus.rd_burst_finish) w_next = DONE;
      WR_BURST: if (bus.wr_burst_finish) w_next = DONE;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant        <= '0;
      r_done         <= '0;
      r_last_grant   <= 2'd2;
      r_rd_burst_req <= 1'b0;
      r_wr_burst_req <= 1'b0;
      r_burst_addr   <= '0;
      r_burst_len    <= '0;
      r_beat_cnt     <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: if (w_found) r_beat_cnt <= '0;
        ARB: begin
          r_beat_cnt <= '0;
          if (w_found) begin
            r_grant        <= w_sel_oh;
            r_last_grant   <= w_sel;
            r_burst_addr   <= w_addr[w_sel];
            r_burst_len    <= w_sel_len;
            r_wr_burst_req <= w_sel_wr;
            r_rd_burst_req <= !w_sel_wr;
          end
        end
        RD_BURST: begin
          if (w_rd_strobe && (r_beat_cnt < r_burst_len)) r_beat_cnt <= r_beat_cnt + c_len_one;
          if (bus.rd_burst_finish) begin
            r_rd_burst_req <= 1'b0;
            r_done         <= r_grant;
          end
        end
        WR_BURST: begin
          if (w_wr_strobe && (r_beat_cnt < r_burst_len)) r_beat_cnt <= r_beat_cnt + c_len_one;
          if (bus.wr_burst_finish) begin
            r_wr_burst_req <= 1'b0;
            r_done         <= r_grant;
          end
        end
        DONE: r_grant <= '0;
        default: ;
      endcase
    end
  end

  assign bus.grant        = r_grant;
  assign bus.done         = r_done;
  assign bus.rd_burst_req = r_rd_burst_req;
  assign bus.wr_burst_req = r_wr_burst_req;
  assign bus.burst_addr   = r_burst_addr;
  assign bus.burst_len    = r_burst_len;
  assign bus.beat_cnt     = r_beat_cnt;
  assign bus.rd_valid     = r_grant & {NUM_REQ{w_rd_strobe}};
  assign bus.wr_data_req  = r_grant & {NUM_REQ{w_wr_strobe}};

endmodule
`default_nettype wire

// File: tb/tb_ddr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_arbiter
// Purpose  : Self-checking bench for ddr_arbiter: a table of single-requester
//            bursts plus hand-written contention, write-before-read, drop,
//            mid-burst reset and strobe-isolation sequences. Expected burst
//            commands are queued when requests are raised and compared when
//            the arbiter issues the command.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_arbiter;
  localparam int AW = 28;
  localparam int LW = 10;

  logic clk = 1'b0;
  logic rst;

  ddr_arbiter_if #(.DDR_ADDR_WIDTH(AW), .BURST_LEN_WIDTH(LW), .NUM_REQ(3)) bus();

  ddr_arbiter #(.DDR_ADDR_WIDTH(AW), .BURST_LEN_WIDTH(LW), .NUM_REQ(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    grant;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    bit            wr;
  } cmd_t;

  typedef struct {
    int            req;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            beats;
    logic [2:0]    exp_grant;
    logic [LW-1:0] exp_len;
    logic [LW-1:0] exp_cnt;
  } vec_t;

  cmd_t sb[$];
  vec_t vecs[5];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [LW-1:0] l);
    bus.req_rd[r]          = rd;
    bus.req_wr[r]          = wr;
    bus.req_addr[r*AW +: AW] = a;
    bus.req_len[r*LW +: LW]  = l;
  endtask

  function automatic int rr_next(input int last, input logic [2:0] pend);
    for (int k = 1; k <= 3; k++) begin
      if (((pend >> ((last + k) % 3)) & 3'b001) != 3'b000) return (last + k) % 3;
    end
    return last;
  endfunction

  // Wait (bounded) for a burst command and compare it with the queue head.
  task automatic wait_cmd(input int exp_lat);
    int   n;
    cmd_t e;
    n = 0;
    while (!(bus.rd_burst_req || bus.wr_burst_req) && n < 20) begin
      tick();
      n++;
    end
    if (!(bus.rd_burst_req || bus.wr_burst_req)) begin
      chk("cmd_timeout", 64'd0, 64'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk("cmd_unexpected", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk("cmd_grant",  bus.grant,        e.grant);
      chk("cmd_addr",   bus.burst_addr,   e.addr);
      chk("cmd_len",    bus.burst_len,    e.len);
      chk("cmd_wr_req", bus.wr_burst_req, e.wr);
      chk("cmd_rd_req", bus.rd_burst_req, !e.wr);
      chk("cmd_latency", n, exp_lat);
      chk("cnt_clear",  bus.beat_cnt,     0);
    end
  endtask

  task automatic do_beats(input int n, input bit wr, input logic [2:0] g);
    for (int b = 0; b < n; b++) begin
      if (wr) bus.wr_burst_data_req = 1'b1;
      else    bus.rd_burst_data_valid = 1'b1;
      #1;
      if (b == 0) chk(wr ? "route_wr" : "route_rd", wr ? bus.wr_data_req : bus.rd_valid, g);
      @(posedge clk);
      #1;
      bus.wr_burst_data_req   = 1'b0;
      bus.rd_burst_data_valid = 1'b0;
    end
  endtask

  task automatic finish_burst(input bit wr, input logic [2:0] g, input logic [LW-1:0] cnt);
    if (wr) bus.wr_burst_finish = 1'b1;
    else    bus.rd_burst_finish = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_burst_finish = 1'b0;
    bus.rd_burst_finish = 1'b0;
    chk("done_pulse", bus.done, g);
    chk("req_drop",   {bus.rd_burst_req, bus.wr_burst_req}, 2'b00);
    chk("beat_cnt",   bus.beat_cnt, cnt);
  endtask

  task automatic after_done();
    tick();
    chk("done_clear",  bus.done,  3'b000);
    chk("grant_clear", bus.grant, 3'b000);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    vec_t v;
    int   last;
    int   g;

    vecs[0] = '{req:1, wr:1'b0, addr:28'h0028000, len:10'd16,   beats:16, exp_grant:3'b010, exp_len:10'd16,   exp_cnt:10'd16};
    vecs[1] = '{req:0, wr:1'b1, addr:28'h0001000, len:10'd4,    beats:4,  exp_grant:3'b001, exp_len:10'd4,    exp_cnt:10'd4};
    vecs[2] = '{req:2, wr:1'b0, addr:28'hFFFFFC0, len:10'd0,    beats:3,  exp_grant:3'b100, exp_len:10'd1,    exp_cnt:10'd1};
    vecs[3] = '{req:1, wr:1'b1, addr:28'h0ABC000, len:10'd8,    beats:10, exp_grant:3'b010, exp_len:10'd8,    exp_cnt:10'd8};
    vecs[4] = '{req:0, wr:1'b0, addr:28'h1234560, len:10'd1023, beats:5,  exp_grant:3'b001, exp_len:10'd1023, exp_cnt:10'd5};

    rst = 1'b0;
    bus.req_rd = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_len = '0;
    bus.rd_burst_data_valid = 1'b0; bus.wr_burst_data_req = 1'b0;
    bus.rd_burst_finish = 1'b0;     bus.wr_burst_finish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", bus.grant, 3'b000);
    chk("rst_done",  bus.done,  3'b000);
    chk("rst_cmd",   {bus.rd_burst_req, bus.wr_burst_req, bus.burst_addr, bus.burst_len, bus.beat_cnt}, 0);
    rst = 1'b1;
    tick();

    // Single-requester table.
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      set_req(v.req, !v.wr, v.wr, v.addr, v.len);
      sb.push_back('{grant: v.exp_grant, addr: v.addr, len: v.exp_len, wr: v.wr});
      wait_cmd(2);
      do_beats(v.beats, v.wr, v.exp_grant);
      finish_burst(v.wr, v.exp_grant, v.exp_cnt);
      set_req(v.req, 1'b0, 1'b0, '0, '0);
      after_done();
    end

    // Contention: all three read from reset, service order 0,1,2,0.
    pulse_reset();
    set_req(0, 1'b1, 1'b0, 28'h0000100, 10'd2);
    set_req(1, 1'b1, 1'b0, 28'h0000200, 10'd2);
    set_req(2, 1'b1, 1'b0, 28'h0000300, 10'd2);
    last = 2;
    for (int k = 0; k < 4; k++) begin
      g = rr_next(last, 3'b111);
      sb.push_back('{grant: 3'b001 << g, addr: 28'h0000100 * (g + 1), len: 10'd2, wr: 1'b0});
      last = g;
    end
    for (int k = 0; k < 4; k++) begin
      g = (k == 3) ? 0 : k;
      wait_cmd(2);
      do_beats(2, 1'b0, 3'b001 << g);
      finish_burst(1'b0, 3'b001 << g, 10'd2);
      if (k == 3) begin
        bus.req_rd = '0;
      end
      after_done();
    end

    // Requester 2 asks for both directions: write first, then read.
    pulse_reset();
    set_req(2, 1'b1, 1'b1, 28'h0ABCDE0, 10'd48);
    sb.push_back('{grant: 3'b100, addr: 28'h0ABCDE0, len: 10'd48, wr: 1'b1});
    sb.push_back('{grant: 3'b100, addr: 28'h0ABCDE0, len: 10'd48, wr: 1'b0});
    wait_cmd(2);
    do_beats(48, 1'b1, 3'b100);
    finish_burst(1'b1, 3'b100, 10'd48);
    bus.req_wr[2] = 1'b0;
    after_done();
    wait_cmd(2);
    do_beats(10, 1'b0, 3'b100);
    // Wrong-direction strobe and finish during a read burst are ignored.
    bus.wr_burst_data_req = 1'b1;
    bus.wr_burst_finish   = 1'b1;
    #1;
    chk("iso_wr_data_req", bus.wr_data_req, 3'b000);
    tick();
    bus.wr_burst_data_req = 1'b0;
    bus.wr_burst_finish   = 1'b0;
    chk("iso_beat_cnt", bus.beat_cnt, 10'd10);
    chk("iso_rd_req",   bus.rd_burst_req, 1'b1);
    do_beats(38, 1'b0, 3'b100);
    finish_burst(1'b0, 3'b100, 10'd48);
    bus.req_rd[2] = 1'b0;
    after_done();
    // Data strobe with no grant is not routed.
    bus.rd_burst_data_valid = 1'b1;
    #1;
    chk("idle_rd_valid", bus.rd_valid, 3'b000);
    tick();
    bus.rd_burst_data_valid = 1'b0;
    chk("idle_beat_cnt", bus.beat_cnt, 10'd48);

    // Request dropped mid-burst still completes with done.
    set_req(0, 1'b1, 1'b0, 28'h0000400, 10'd4);
    sb.push_back('{grant: 3'b001, addr: 28'h0000400, len: 10'd4, wr: 1'b0});
    wait_cmd(2);
    do_beats(2, 1'b0, 3'b001);
    bus.req_rd[0] = 1'b0;
    do_beats(2, 1'b0, 3'b001);
    finish_burst(1'b0, 3'b001, 10'd4);
    after_done();

    // Reset in the middle of a burst abandons it silently.
    set_req(1, 1'b1, 1'b0, 28'h0000500, 10'd8);
    sb.push_back('{grant: 3'b010, addr: 28'h0000500, len: 10'd8, wr: 1'b0});
    wait_cmd(2);
    do_beats(3, 1'b0, 3'b010);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_grant", bus.grant, 3'b000);
    chk("mid_rst_cmd",   {bus.rd_burst_req, bus.wr_burst_req, bus.burst_addr, bus.burst_len, bus.beat_cnt}, 0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_rst_no_done", {bus.done, bus.grant}, 6'b0);
    end

    // After reset requester 0 wins over requester 1.
    set_req(0, 1'b1, 1'b0, 28'h0000600, 10'd1);
    set_req(1, 1'b1, 1'b0, 28'h0000700, 10'd1);
    sb.push_back('{grant: 3'b001, addr: 28'h0000600, len: 10'd1, wr: 1'b0});
    wait_cmd(2);
    do_beats(1, 1'b0, 3'b001);
    finish_burst(1'b0, 3'b001, 10'd1);
    bus.req_rd = '0;
    after_done();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr_arbiter.md
DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 SHALL have parameter DDR_ADDR_WIDTH, default 28, DDR byte-address width.
REQ-002 SHALL have parameter BURST_LEN_WIDTH, default 10, burst-length and beat-counter width.
REQ-003 SHALL have parameter NUM_REQ, fixed at 3; requester 0 = instruction cache, 1 = data cache, 2 = context save/restore.
REQ-004 SHALL have clk  input  1  system clock, rising-edge.
REQ-005 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have req_rd  input  3  per-requester read-burst request, level, held until its done pulse.
REQ-007 SHALL have req_wr  input  3  per-requester write-burst request, level, held until its done pulse.
REQ-008 SHALL have req_addr  input  3*DDR_ADDR_WIDTH  per-requester start address; requester i occupies slice i.
REQ-009 SHALL have req_len  input  3*BURST_LEN_WIDTH  per-requester burst length in beats (1..1023).
REQ-010 SHALL have grant  output  3  one-hot grant of the active requester, or zero.
REQ-011 SHALL have done  output  3  one-cycle pulse to the granted requester at burst completion.
REQ-012 SHALL have rd_valid  output  3  rd_burst_data_valid routed to the granted requester only.
REQ-013 SHALL have wr_data_req  output  3  wr_burst_data_req routed to the granted requester only.
REQ-014 SHALL have rd_burst_req / wr_burst_req  output  1 each  burst requests to the DDR controller.
REQ-015 SHALL have burst_addr  output  DDR_ADDR_WIDTH and burst_len  output  BURST_LEN_WIDTH  registered command to the DDR controller.
REQ-016 SHALL have rd_burst_data_valid, wr_burst_data_req, rd_burst_finish, wr_burst_finish  input  1 each  from the DDR controller.
REQ-017 SHALL have beat_cnt  output  BURST_LEN_WIDTH  beats transferred in the current burst.

Function
REQ-018 SHALL implement states IDLE, ARB, RD_BURST, WR_BURST, DONE.
REQ-019 IDLE: if any req_rd|req_wr bit is set, SHALL go to ARB next cycle; otherwise stay.
REQ-020 ARB: SHALL select a requester round-robin, searching from (last_grant+1) mod 3; last_grant resets to 2 so requester 0 wins first.
REQ-021 ARB: if the selected requester asserts both req_wr and req_rd, SHALL serve the write first.
REQ-022 ARB: SHALL register grant, burst_addr, burst_len and last_grant, assert the matching burst request, and enter RD_BURST or WR_BURST the next cycle.
REQ-023 rd_burst_req/wr_burst_req SHALL stay high from ARB exit until rd_burst_finish/wr_burst_finish is sampled high.
REQ-024 RD_BURST: beat_cnt SHALL increment on each cycle with rd_burst_data_valid=1; WR_BURST: on each cycle with wr_burst_data_req=1.
REQ-025 beat_cnt SHALL saturate at burst_len and clear on entry to ARB.
REQ-026 On the finish input for the active direction, SHALL drop the burst request and enter DONE.
REQ-027 DONE: SHALL pulse done[granted] for exactly one cycle, clear grant, and go to IDLE.
REQ-028 Total request-to-command latency SHALL be 2 cycles (IDLE->ARB->burst).
REQ-029 Bus turnaround SHALL be 1 idle cycle in IDLE before re-arbitration.
REQ-030 The finish input of the inactive direction and data strobes with grant=0 SHALL be ignored.
REQ-031 rd_valid and wr_data_req SHALL be combinational AND of the DDR strobe with grant and the active state.
REQ-032 A requester dropping its request mid-burst SHALL NOT abort the burst; the burst completes and done is still pulsed.
REQ-033 A requester re-asserting in the cycle after its done SHALL be deferred to the other pending requesters (round-robin fairness).
REQ-034 req_len=0 SHALL be treated as 1.
REQ-035 SHALL hold at most one outstanding burst; grant SHALL be one-hot or zero at all times.

Reset
REQ-036 On rst low, asynchronously: state=IDLE, grant=0, done=0, rd_burst_req=wr_burst_req=0, burst_addr=0, burst_len=0, beat_cnt=0, last_grant=2.
REQ-037 Reset asserted mid-burst SHALL abandon the burst with no done pulse; operation resumes from IDLE after release.

Verification
REQ-038 Single read: req_rd=3'b010, addr 0x28000, len 16; 16 valid beats then finish -> grant=3'b010 two cycles after request, burst_addr=0x28000, beat_cnt=16, done[1] pulse.
REQ-039 Contention: all three req_rd high from reset -> service order 0,1,2,0 with an IDLE cycle between bursts.
REQ-040 Read+write from requester 2 (len 48) -> write burst served first, then read; two done[2] pulses.
REQ-041 Request dropped mid-burst and reset mid-burst: first completes with done; second leaves all outputs zero and no done.
REQ-042 Strobe isolation: wr_burst_data_req pulsed while in RD_BURST -> wr_data_req stays 0, beat_cnt unchanged.
